memory_stage: RTL and testbench

Pipeline memory stage sitting directly downstream of `execute`: it consumes the ALU result, store data and write-back controls, and performs byte/half/word loads and stores over a request/grant/rvalid data bus. It selects the final write-back value (ALU result, extended load data or PC+4) and registers it for the register file. While a bus access is outstanding it back-pressures `execute` through `ex_ready`.

---
 rtl/memory_stage.sv | 170 +++++++++++++++++
 tb/tb_memory_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: load/store unit with request/grant/rvalid bus and registered write-back.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned H/W accesses instead of issuing them.
module memory_stage #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [2:0]               funct3,
  input  logic [DATA_WIDTH-1:0]    ALUout,
  input  logic [DATA_WIDTH-1:0]    WriteData,
  input  logic [DATA_WIDTH-1:0]    PCPlus4,
  input  logic [1:0]               ResultSrc,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic                     RegWrite,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_addr,
  output logic [3:0]               mem_be,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     wb_valid,
  output logic [ADDRESS_WIDTH-1:0] wb_rd,
  output logic                     wb_RegWrite,
  output logic [DATA_WIDTH-1:0]    wb_result,
  output logic                     wb_err
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  logic [1:0] state_q, state_d;
  logic we_q, we_d, ld_q, ld_d, rw_q, rw_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, res_q, res_d;
  logic [3:0] be_q, be_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d, wb_err_q, wb_err_d;
  logic [31:0] wb_res_q, wb_res_d;
  logic accept, mem_op, is_b, is_h, mis;
  logic [31:0] sel, ext;
  logic [7:0] bsel;
  logic [15:0] hsel;
  assign accept = ex_valid && state_q == IDLE;
  assign mem_op = MemRead || MemWrite;
  assign is_b   = funct3[1:0] == 2'b00;
  assign is_h   = funct3[1:0] == 2'b01;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = (is_h && ALUout[0]) || (!is_b && !is_h && |ALUout[1:0]);
`else
  assign mis = 1'b0;
`endif
  assign sel  = ResultSrc == 2'b10 ? PCPlus4 : ALUout;
  assign bsel = off_q[1] ? (off_q[0] ? mem_rdata[31:24] : mem_rdata[23:16])
                         : (off_q[0] ? mem_rdata[15:8]  : mem_rdata[7:0]);
  assign hsel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  assign ext  = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & bsel[7]}}, bsel} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & hsel[15]}}, hsel} : mem_rdata;
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    addr_d = addr_q;
    be_d = be_q;
    wdata_d = wdata_q;
    f3_d = f3_q;
    off_d = off_q;
    ld_d = ld_q;
    res_d = res_q;
    rd_d = rd_q;
    rw_d = rw_q;
    wb_valid_d = 1'b0;
    wb_rd_d = wb_rd_q;
    wb_rw_d = wb_rw_q;
    wb_res_d = wb_res_q;
    wb_err_d = wb_err_q;
    case (state_q)
      IDLE: if (accept) begin
        if (mem_op && !mis) begin
          state_d = REQ;
          we_d = MemWrite;
          addr_d = {ALUout[31:2], 2'b00};
          be_d = is_b ? 4'b0001 << ALUout[1:0] : is_h ? (ALUout[1] ? 4'b1100 : 4'b0011) : 4'b1111;
          wdata_d = is_b ? {4{WriteData[7:0]}} : is_h ? {2{WriteData[15:0]}} : WriteData;
          f3_d = funct3;
          off_d = ALUout[1:0];
          ld_d = ResultSrc == 2'b01;
          res_d = sel;
          rd_d = rd;
          rw_d = RegWrite;
        end else begin
          // a mem op reaching here is a trapped misaligned access
          wb_valid_d = 1'b1;
          wb_rd_d = rd;
          wb_rw_d = RegWrite && !mem_op;
          wb_res_d = sel;
          wb_err_d = mem_op;
        end
      end
      REQ: if (mem_gnt) begin
        state_d = we_q ? IDLE : WAIT;
        wb_valid_d = we_q;
        wb_rd_d = we_q ? rd_q : wb_rd_q;
        wb_rw_d = we_q ? 1'b0 : wb_rw_q;
        wb_res_d = we_q ? res_q : wb_res_q;
        wb_err_d = we_q ? 1'b0 : wb_err_q;
      end
      WAIT: if (mem_rvalid) begin
        state_d = IDLE;
        wb_valid_d = 1'b1;
        wb_rd_d = rd_q;
        wb_rw_d = rw_q;
        wb_res_d = ld_q ? ext : res_q;
        wb_err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      addr_q <= '0;
      be_q <= '0;
      wdata_q <= '0;
      f3_q <= '0;
      off_q <= '0;
      ld_q <= 1'b0;
      res_q <= '0;
      rd_q <= '0;
      rw_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_rw_q <= 1'b0;
      wb_res_q <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      addr_q <= addr_d;
      be_q <= be_d;
      wdata_q <= wdata_d;
      f3_q <= f3_d;
      off_q <= off_d;
      ld_q <= ld_d;
      res_q <= res_d;
      rd_q <= rd_d;
      rw_q <= rw_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q <= wb_rd_d;
      wb_rw_q <= wb_rw_d;
      wb_res_q <= wb_res_d;
      wb_err_q <= wb_err_d;
    end
  end
  assign ex_ready    = state_q == IDLE;
  assign mem_req     = state_q == REQ;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_be      = be_q;
  assign mem_wdata   = wdata_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_RegWrite = wb_rw_q;
  assign wb_result   = wb_res_q;
  assign wb_err      = wb_err_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: scenario tasks with a write-back scoreboard for memory_stage.
module tb_memory_stage;
  typedef struct packed {
    logic [4:0] rd;
    logic rw;
    logic [31:0] res;
    logic err;
  } wb_t;
  typedef struct packed {
    logic we;
    logic [31:0] addr;
    logic [3:0] be;
    logic [31:0] wdata;
  } bus_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ex_valid = 1'b0, ex_ready, MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] ALUout = '0, WriteData = '0, PCPlus4 = '0, mem_rdata = '0;
  logic [1:0] ResultSrc = '0;
  logic [4:0] rd = '0;
  logic mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_addr, mem_wdata, wb_result;
  logic [3:0] mem_be;
  logic wb_valid, wb_RegWrite, wb_err;
  logic [4:0] wb_rd;
  int errors = 0, checks = 0;
  int lat, req_cyc, nrdy;
  wb_t got, exp, sb[$];
  bus_t bus;
  memory_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3), .ALUout(ALUout),
    .WriteData(WriteData), .PCPlus4(PCPlus4), .ResultSrc(ResultSrc), .rd(rd),
    .RegWrite(RegWrite), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
    .wb_result(wb_result), .wb_err(wb_err)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic mr, input logic mw, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4, input logic [1:0] rs,
                       input logic [4:0] d, input logic w);
    MemRead = mr; MemWrite = mw; funct3 = f3; ALUout = alu; WriteData = wd;
    PCPlus4 = pc4; ResultSrc = rs; rd = d; RegWrite = w; ex_valid = 1'b1;
  endtask
  // Plays the bus side until write-back appears; lat counts negedges after the accept edge.
  task automatic run_op(input int gnt_wait, input int rv_wait, input logic is_ld, input logic [31:0] rdata);
    int k, g;
    logic done;
    lat = -1; req_cyc = 0; nrdy = 0; k = 0; g = 0; done = 1'b0; mem_rdata = rdata; bus = '0;
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      ex_valid = 1'b0;
      if (wb_valid) begin
        lat = n;
        got = {wb_rd, wb_RegWrite, wb_result, wb_err};
        done = 1'b1;
      end else begin
        if (!ex_ready) nrdy++;
        if (mem_req) begin
          if (req_cyc == 0) bus = {mem_we, mem_addr, mem_be, mem_wdata};
          req_cyc++;
          k++;
        end
        g = g > 0 ? g + 1 : 0;
        mem_gnt = mem_req && k > gnt_wait && g == 0;
        if (mem_gnt) g = 1;
        mem_rvalid = is_ld && g >= 2 + rv_wait;
      end
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (sb.size() > 0) exp = sb.pop_front();
    else exp = '0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({mem_req, mem_we, wb_valid, wb_RegWrite, wb_err} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, wb_valid, wb_RegWrite, wb_err});
    end
    checks++; if ({mem_addr, mem_be, mem_wdata, wb_rd, wb_result} !== '0) begin
      errors++; $display("FAIL reset_data got addr=%h be=%b wd=%h rd=%0d res=%h exp all 0", mem_addr, mem_be, mem_wdata, wb_rd, wb_result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ex_ready); end
  endtask
  task automatic test_nonmem;
    sb.push_back('{rd: 5'd5, rw: 1'b1, res: 32'h0000_1234, err: 1'b0});
    drive(0, 0, 3'b010, 32'h0000_1234, 32'h0, 32'h0, 2'b00, 5'd5, 1'b1);
    run_op(0, 0, 1'b0, 32'h0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL nonmem_lat got=%0d exp=1", lat); end
    checks++; if (got !== exp) begin errors++; $display("FAIL nonmem_wb got=%h exp=%h", got, exp); end
    checks++; if (nrdy !== 0 || req_cyc !== 0) begin errors++; $display("FAIL nonmem_ready got nrdy=%0d req=%0d exp 0 0", nrdy, req_cyc); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL nonmem_pulse got=%b exp=0", wb_valid); end
  endtask
  task automatic test_jal;
    sb.push_back('{rd: 5'd1, rw: 1'b1, res: 32'h44, err: 1'b0});
    drive(0, 0, 3'b000, 32'h0000_0800, 32'h0, 32'h44, 2'b10, 5'd1, 1'b1);
    run_op(0, 0, 1'b0, 32'h0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL jal_lat got=%0d exp=1", lat); end
    checks++; if (got !== exp) begin errors++; $display("FAIL jal_wb got=%h exp=%h", got, exp); end
  endtask
  task automatic test_store;
    sb.push_back('{rd: 5'd9, rw: 1'b0, res: 32'h103, err: 1'b0});
    drive(0, 1, 3'b000, 32'h103, 32'h0000_00AB, 32'h0, 2'b00, 5'd9, 1'b1);
    run_op(0, 0, 1'b0, 32'h0);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sb_lat got=%0d exp=2", lat); end
    checks++; if (bus !== {1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB}) begin
      errors++; $display("FAIL sb_bus got=%h exp=%h", bus, {1'b1, 32'h100, 4'b1000, 32'hABAB_ABAB});
    end
    checks++; if (got !== exp) begin errors++; $display("FAIL sb_wb got=%h exp=%h", got, exp); end
    sb.push_back('{rd: 5'd0, rw: 1'b0, res: 32'h102, err: 1'b0});
    drive(0, 1, 3'b001, 32'h102, 32'h1234_CDEF, 32'h0, 2'b00, 5'd0, 1'b0);
    run_op(0, 0, 1'b0, 32'h0);
    checks++; if (bus !== {1'b1, 32'h100, 4'b1100, 32'hCDEF_CDEF}) begin
      errors++; $display("FAIL sh_bus got=%h exp=%h", bus, {1'b1, 32'h100, 4'b1100, 32'hCDEF_CDEF});
    end
    checks++; if (got !== exp) begin errors++; $display("FAIL sh_wb got=%h exp=%h", got, exp); end
  endtask
  task automatic test_loads;
    sb.push_back('{rd: 5'd7, rw: 1'b1, res: 32'hFFFF_FF80, err: 1'b0});
    drive(1, 0, 3'b000, 32'h202, 32'h0, 32'h0, 2'b01, 5'd7, 1'b1);
    run_op(0, 0, 1'b1, 32'h0080_0000);
    checks++; if (lat !== 3 || nrdy !== 2) begin errors++; $display("FAIL lb_lat got lat=%0d nrdy=%0d exp 3 2", lat, nrdy); end
    checks++; if (bus !== {1'b0, 32'h200, 4'b0100, 32'h0}) begin
      errors++; $display("FAIL lb_bus got=%h exp=%h", bus, {1'b0, 32'h200, 4'b0100, 32'h0});
    end
    checks++; if (got !== exp) begin errors++; $display("FAIL lb_wb got=%h exp=%h", got, exp); end
    sb.push_back('{rd: 5'd8, rw: 1'b1, res: 32'h0000_0080, err: 1'b0});
    drive(1, 0, 3'b100, 32'h202, 32'h0, 32'h0, 2'b01, 5'd8, 1'b1);
    run_op(0, 0, 1'b1, 32'h0080_0000);
    checks++; if (got !== exp) begin errors++; $display("FAIL lbu_wb got=%h exp=%h", got, exp); end
    sb.push_back('{rd: 5'd10, rw: 1'b1, res: 32'hFFFF_8001, err: 1'b0});
    drive(1, 0, 3'b001, 32'h102, 32'h0, 32'h0, 2'b01, 5'd10, 1'b1);
    run_op(0, 1, 1'b1, 32'h8001_7FFF);
    checks++; if (lat !== 4) begin errors++; $display("FAIL lh_lat got=%0d exp=4", lat); end
    checks++; if (got !== exp) begin errors++; $display("FAIL lh_wb got=%h exp=%h", got, exp); end
    sb.push_back('{rd: 5'd11, rw: 1'b1, res: 32'h0000_7FFF, err: 1'b0});
    drive(1, 0, 3'b101, 32'h100, 32'h0, 32'h0, 2'b01, 5'd11, 1'b1);
    run_op(0, 0, 1'b1, 32'h8001_7FFF);
    checks++; if (got !== exp) begin errors++; $display("FAIL lhu_wb got=%h exp=%h", got, exp); end
  endtask
  task automatic test_grant_stall;
    sb.push_back('{rd: 5'd12, rw: 1'b1, res: 32'hDEAD_BEEF, err: 1'b0});
    drive(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, 2'b01, 5'd12, 1'b1);
    run_op(3, 0, 1'b1, 32'hDEAD_BEEF);
    checks++; if (req_cyc !== 4) begin errors++; $display("FAIL stall_req got=%0d exp=4", req_cyc); end
    checks++; if (lat !== 6 || nrdy !== 5) begin errors++; $display("FAIL stall_lat got lat=%0d nrdy=%0d exp 6 5", lat, nrdy); end
    checks++; if (got !== exp) begin errors++; $display("FAIL stall_wb got=%h exp=%h", got, exp); end
  endtask
  task automatic test_misaligned;
`ifdef MEM_MISALIGN_TRAP_EN
    sb.push_back('{rd: 5'd13, rw: 1'b0, res: 32'h301, err: 1'b1});
    drive(1, 0, 3'b010, 32'h301, 32'h0, 32'h0, 2'b01, 5'd13, 1'b1);
    run_op(0, 0, 1'b1, 32'h1111_2222);
    checks++; if (lat !== 1 || req_cyc !== 0) begin errors++; $display("FAIL mis_trap got lat=%0d req=%0d exp 1 0", lat, req_cyc); end
    checks++; if (got !== exp) begin errors++; $display("FAIL mis_wb got=%h exp=%h", got, exp); end
`else
    sb.push_back('{rd: 5'd13, rw: 1'b1, res: 32'h1111_2222, err: 1'b0});
    drive(1, 0, 3'b010, 32'h301, 32'h0, 32'h0, 2'b01, 5'd13, 1'b1);
    run_op(0, 0, 1'b1, 32'h1111_2222);
    checks++; if (lat !== 3 || bus !== {1'b0, 32'h300, 4'b1111, 32'h0}) begin
      errors++; $display("FAIL mis_bus got lat=%0d bus=%h exp 3 %h", lat, bus, {1'b0, 32'h300, 4'b1111, 32'h0});
    end
    checks++; if (got !== exp) begin errors++; $display("FAIL mis_wb got=%h exp=%h", got, exp); end
`endif
  endtask
  task automatic test_back_to_back;
    sb.push_back('{rd: 5'd14, rw: 1'b0, res: 32'h500, err: 1'b0});
    drive(0, 1, 3'b010, 32'h500, 32'h5555_AAAA, 32'h0, 2'b00, 5'd14, 1'b1);
    run_op(0, 0, 1'b0, 32'h0);
    checks++; if (got !== exp || ex_ready !== 1'b1) begin errors++; $display("FAIL b2b_first got=%h rdy=%b exp=%h 1", got, ex_ready, exp); end
    sb.push_back('{rd: 5'd15, rw: 1'b1, res: 32'h0000_0ABC, err: 1'b0});
    drive(0, 0, 3'b000, 32'h0000_0ABC, 32'h0, 32'h0, 2'b11, 5'd15, 1'b1);
    run_op(0, 0, 1'b0, 32'h0);
    checks++; if (lat !== 1 || got !== exp) begin errors++; $display("FAIL b2b_second got lat=%0d wb=%h exp 1 %h", lat, got, exp); end
  endtask
  task automatic test_reset_mid;
    int seen;
    seen = 0;
    drive(1, 0, 3'b010, 32'h600, 32'h0, 32'h0, 2'b01, 5'd16, 1'b1);
    @(negedge clk);
    ex_valid = 1'b0;
    mem_gnt = mem_req;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL rstmid_state got req=%b rdy=%b exp 0 1", mem_req, ex_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    mem_rdata = 32'h7777_7777;
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid || mem_req) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_nowb got=%0d active cycles exp=0", seen); end
  endtask
  initial begin
    test_reset;
    test_nonmem;
    test_jal;
    test_store;
    test_loads;
    test_grant_stall;
    test_misaligned;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
